serial_subtractor: RTL and testbench

Parametrised multi-bit subtractor computing `diff = a - b - bin` over several clock cycles, DIGIT_W bits per cycle, least-significant digit first. A borrow register carries the borrow between digits. It extends the single-bit half-subtract cell with operand width, a borrow-in, and a start/busy/done handshake. It is used where a full-width combinational borrow chain would not fit the clock period or the area budget.

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes diff = a - b - bin over NDIG = WIDTH/DIGIT_W
// clock cycles, DIGIT_W bits per cycle, least-significant digit first.
// A borrow register chains the digits. The start/busy/done handshake frames
// each operation, and every output is registered.
// Parameter constraints: WIDTH >= 1, 1 <= DIGIT_W <= WIDTH, WIDTH % DIGIT_W == 0.
module serial_subtractor #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sr;      // minuend, shifted right one digit per RUN cycle
    logic [WIDTH-1:0]   b_sr;      // subtrahend, shifted in step with a_sr
    logic [WIDTH-1:0]   acc;       // partial difference, filled from the MSB end
    logic               br;        // borrow into the current digit
    logic [CNT_W-1:0]   cnt;       // index of the digit being processed
    logic               a_msb;     // latched operand sign bits for the overflow flag
    logic               b_msb;

    logic [DIGIT_W-1:0] d;         // current digit of the difference
    logic               nb;        // borrow out of the current digit
    logic [WIDTH-1:0]   acc_next;  // accumulator after inserting d

    // Digit cell: one DIGIT_W-wide subtract with borrow, and the accumulator after it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nb       = 1'b0;
        d        = '0;
        acc_next = acc;
        {nb, d}  = {1'b0, a_sr[DIGIT_W-1:0]} - {1'b0, b_sr[DIGIT_W-1:0]}
                 - {{DIGIT_W{1'b0}}, br};
        acc_next = (acc >> DIGIT_W) | (WIDTH'(d) << (WIDTH - DIGIT_W));
    end

    // Control FSM, operand shift registers and registered result outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        acc   <= '0;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not examined here: requests during RUN are dropped.
                    a_sr <= a_sr >> DIGIT_W;
                    b_sr <= b_sr >> DIGIT_W;
                    acc  <= acc_next;
                    br   <= nb;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_DIG) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= acc_next;
                        bout  <= nb;
                        ovf   <= (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: three builds (DIGIT_W = 2, 1, 8; WIDTH = 8) checked
// every cycle against an arithmetic reference model, plus directed cases with
// hand-computed expectations on the DIGIT_W = 2 build.
module tb_serial_subtractor;

    localparam int W     = 8;
    localparam int NI    = 3;
    localparam int SWEEP = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         chk_en = 1'b0;
    logic         start [NI];
    logic [W-1:0] a     [NI];
    logic [W-1:0] b     [NI];
    logic         bin   [NI];
    logic         busy  [NI];
    logic         done  [NI];
    logic [W-1:0] diff  [NI];
    logic         bout  [NI];
    logic         ovf   [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int dw_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int DW = (g == 0) ? 2 : (g == 1) ? 1 : 8;
        serial_subtractor #(.WIDTH(W), .DIGIT_W(DW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start[g]),
            .a     (a[g]),
            .b     (b[g]),
            .bin   (bin[g]),
            .busy  (busy[g]),
            .done  (done[g]),
            .diff  (diff[g]),
            .bout  (bout[g]),
            .ovf   (ovf[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an operation accepted at an edge yields its result
    // NDIG edges later; results come straight from integer arithmetic.
    // ------------------------------------------------------------------
    int           cd     [NI];  // edges remaining until the result appears, 0 = not running
    logic         m_busy [NI];
    logic         m_done [NI];
    logic         m_valid[NI];  // result outputs are defined and must be checked
    logic [W-1:0] m_diff [NI];
    logic         m_bout [NI];
    logic         m_ovf  [NI];
    logic [W-1:0] p_diff [NI];
    logic         p_bout [NI];
    logic         p_ovf  [NI];
    int           ndone  [NI] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int ua, ub, sa, sb, ib;
            ua = int'(a[k]);
            ub = int'(b[k]);
            sa = int'($signed(a[k]));
            sb = int'($signed(b[k]));
            ib = int'(bin[k]);
            if (!rst_n) begin
                cd[k]      <= 0;
                m_busy[k]  <= 1'b0;
                m_done[k]  <= 1'b0;
                m_valid[k] <= 1'b1;
                m_diff[k]  <= '0;
                m_bout[k]  <= 1'b0;
                m_ovf[k]   <= 1'b0;
            end else if (cd[k] > 0) begin
                cd[k]     <= cd[k] - 1;
                m_done[k] <= (cd[k] == 1);
                if (cd[k] == 1) begin
                    m_busy[k]  <= 1'b0;
                    m_valid[k] <= 1'b1;
                    m_diff[k]  <= p_diff[k];
                    m_bout[k]  <= p_bout[k];
                    m_ovf[k]   <= p_ovf[k];
                    ndone[k]   <= ndone[k] + 1;
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start[k] === 1'b1) begin
                    cd[k]      <= W / dw_of(k);
                    m_busy[k]  <= 1'b1;
                    m_valid[k] <= 1'b0;
                    p_diff[k]  <= W'(ua - ub - ib);
                    p_bout[k]  <= (ua < ub + ib);
                    p_ovf[k]   <= ((sa - sb - ib) < -128) || ((sa - sb - ib) > 127);
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("busy[%0d]", k), busy[k], m_busy[k]);
                check($sformatf("done[%0d]", k), done[k], m_done[k]);
                check($sformatf("busy_and_done[%0d]", k), busy[k] & done[k], 1'b0);
                if (m_valid[k]) begin
                    check($sformatf("diff[%0d]", k), diff[k], m_diff[k]);
                    check($sformatf("bout[%0d]", k), bout[k], m_bout[k]);
                    check($sformatf("ovf[%0d]", k),  ovf[k],  m_ovf[k]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (DIGIT_W = 2 build, NDIG = 4)
    // ------------------------------------------------------------------
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        a[0]     = ta;
        b[0]     = tb_v;
        bin[0]   = tbin;
        start[0] = 1'b1;
    endtask

    // Counts cycles after acceptance until done; poke_at > 0 re-asserts start
    // with different operands in that cycle.
    task automatic wait_done(input int poke_at, output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy[0]) busy_cyc++;
            if (cyc == poke_at) begin
                start[0] = 1'b1;
                a[0]     = 8'hFF;
                b[0]     = 8'hFF;
            end else begin
                start[0] = 1'b0;
            end
            if (done[0]) break;
            if (cyc >= 40) begin
                check("done_timeout", done[0], 1'b1);
                break;
            end
        end
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] ed,
                                 input logic eb, input logic eo);
        check({name, "_diff"}, diff[0], ed);
        check({name, "_bout"}, bout[0], eb);
        check({name, "_ovf"},  ovf[0],  eo);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int cyc, bcyc, nd;
        int base [NI];

        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0;
            a[k]     = '0;
            b[k]     = '0;
            bin[k]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        check("rst_diff", diff[0], 8'h00);
        check("rst_bout", bout[0], 1'b0);
        check("rst_ovf",  ovf[0],  1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtract
        issue(8'h35, 8'h12, 1'b0);
        wait_done(0, cyc, bcyc);
        check("basic_latency", cyc, 5);
        check("basic_busy_cycles", bcyc, 4);
        expect_result("basic", 8'h23, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Unsigned underflow
        issue(8'h12, 8'h35, 1'b0);
        wait_done(0, cyc, bcyc);
        expect_result("underflow", 8'hDD, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Signed overflow, then back-to-back issue with borrow-in
        issue(8'h80, 8'h01, 1'b0);
        wait_done(0, cyc, bcyc);
        expect_result("overflow", 8'h7F, 1'b0, 1'b1);
        issue(8'h00, 8'h00, 1'b1);
        wait_done(0, cyc, bcyc);
        check("b2b_latency", cyc, 5);
        expect_result("b2b_bin", 8'hFF, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // start ignored while busy
        issue(8'h10, 8'h01, 1'b0);
        wait_done(2, cyc, bcyc);
        check("ignore_latency", cyc, 5);
        check("ignore_busy_cycles", bcyc, 4);
        expect_result("ignore", 8'h0F, 1'b0, 1'b0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0] || busy[0]) nd++;
        end
        check("ignore_no_extra", nd, 0);

        // Reset in the 3rd RUN cycle
        issue(8'h99, 8'h11, 1'b0);
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_done", done[0], 1'b0);
        check("midrst_diff", diff[0], 8'h00);
        check("midrst_bout", bout[0], 1'b0);
        check("midrst_ovf",  ovf[0],  1'b0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        check("midrst_no_done", nd, 0);
        issue(8'h99, 8'h11, 1'b0);
        wait_done(0, cyc, bcyc);
        check("midrst_restart_latency", cyc, 5);
        expect_result("midrst_restart", 8'h88, 1'b0, 1'b0);
        @(negedge clk);

        // Random sweep on all three builds, start requested on random cycles
        for (int k = 0; k < NI; k++) base[k] = ndone[k];
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            if (ndone[0] - base[0] >= SWEEP && ndone[1] - base[1] >= SWEEP &&
                ndone[2] - base[2] >= SWEEP) break;
            for (int k = 0; k < NI; k++) begin
                start[k] = ($urandom_range(0, 99) < 60);
                a[k]     = rand_operand();
                b[k]     = rand_operand();
                bin[k]   = 1'($urandom_range(0, 1));
            end
        end
        for (int k = 0; k < NI; k++) start[k] = 1'b0;
        repeat (12) @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("sweep_ops[%0d]", k), (ndone[k] - base[k]) >= SWEEP, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
